// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter run/pause/clear controller.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int unsigned DB_CYCLES_DEF = 1000000;
  localparam int          DB_CNT_W      = 24;

endpackage

// File: rtl/counter_ctrl_if.sv
// Controller <-> external counter bundle: counter value/limit in, enable/clear/wrap/state out.
interface counter_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_max;
  logic             cnt_en;
  logic             cnt_clr;
  logic             wrap;
  logic [1:0]       state;

  modport master (
    input  count, cnt_max,
    output cnt_en, cnt_clr, wrap, state
  );

  modport slave (
    output count, cnt_max,
    input  cnt_en, cnt_clr, wrap, state
  );
endinterface

// File: rtl/counter_ctrl_btn_debounce.sv
// Raw push-button -> 2-flop sync -> debounced level -> registered one-cycle press pulse.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] TC = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                level;
  logic [DB_CNT_W-1:0] cnt;

  // cnt holds the number of consecutive differing samples already seen;
  // the DB_CYCLES-th one flips the level and, on a rising level, fires press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/clear controller for an external counter with terminal-count wrap.
// Define COUNTER_CTRL_ONESHOT_EN to return to IDLE on terminal count instead of free-running.
//
// state | meaning
// IDLE  | counter held, waiting for run press
// RUN   | counter enabled, terminal count watched
// PAUSE | counter frozen, run press resumes
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_run,
  input  logic           btn_clr,
  counter_ctrl_if.master cif
);

  state_t           state_q, state_d;
  logic             en_q, clr_q, wrap_q;
  logic             en_d, clr_d, wrap_d;
  logic             run_ev, clr_ev, tc;
  logic [CNT_W-1:0] count_w, max_w;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_run),
    .press (run_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .press (clr_ev)
  );

  assign count_w = cif.count;
  assign max_w   = cif.cnt_max;
  assign tc      = (state_q == ST_RUN) && (count_w == max_w);

  always_comb begin
    state_d = state_q;
    if (clr_ev) begin
      state_d = ST_IDLE;
    end else begin
      if (run_ev) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end
`ifdef COUNTER_CTRL_ONESHOT_EN
      if (tc) state_d = ST_IDLE;
`endif
    end
    en_d   = (state_d == ST_RUN);
    clr_d  = clr_ev || tc;
    wrap_d = tc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cif.state   = state_q;
  assign cif.cnt_en  = en_q;
  assign cif.cnt_clr = clr_q;
  assign cif.wrap    = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: vector table, corner sequences, random vs reference model.
module tb_counter_ctrl;

  localparam int DB = 4;
  localparam logic [1:0] M_IDLE = 2'b00, M_RUN = 2'b01, M_PAUSE = 2'b10;
`ifdef COUNTER_CTRL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;

  counter_ctrl_if #(.CNT_W(32)) cif ();

  counter_ctrl #(.CNT_W(32), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
    .cif     (cif.master)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // full press and release, leaving the buttons quiet again
  task automatic press(input bit r, input bit c);
    btn_run = r;
    btn_clr = c;
    repeat (DB + 3) tick();
    btn_run = 1'b0;
    btn_clr = 1'b0;
    repeat (DB + 3) tick();
  endtask

  typedef struct {
    logic [31:0] max;
    logic [31:0] cnt;
    bit          exp_wrap;
  } wrap_vec_t;

  // reference model: presses detected by a sliding window over raw samples
  logic [1:0] m_state;
  bit m_en, m_clr, m_wrap, pend_run, pend_clr, lvl_run, lvl_clr;
  bit hr[$];
  bit hc[$];

  function automatic bit window_all(input bit q[$], input bit v);
    for (int k = 0; k < DB; k++)
      if (q[q.size() - 3 - k] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_en = 0; m_clr = 0; m_wrap = 0;
    pend_run = 0; pend_clr = 0; lvl_run = 0; lvl_clr = 0;
    hr = {}; hc = {};
    for (int k = 0; k < DB + 2; k++) begin
      hr.push_back(1'b0);
      hc.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit tc;
    logic [1:0] nxt;
    tc  = (m_state == M_RUN) && (cif.count == cif.cnt_max);
    nxt = m_state;
    if (pend_clr) nxt = M_IDLE;
    else begin
      if (pend_run) nxt = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      if (ONESHOT && tc) nxt = M_IDLE;
    end
    m_clr = pend_clr || tc;
    m_wrap = tc;
    m_state = nxt;
    m_en = (nxt == M_RUN);
    hr.push_back(btn_run);
    hc.push_back(btn_clr);
    pend_run = 0;
    pend_clr = 0;
    if (window_all(hr, !lvl_run)) begin lvl_run = !lvl_run; pend_run = lvl_run; end
    if (window_all(hc, !lvl_clr)) begin lvl_clr = !lvl_clr; pend_clr = lvl_clr; end
    void'(hr.pop_front());
    void'(hc.pop_front());
  endtask

  initial begin
    wrap_vec_t vecs[8];
    logic [1:0] s0;
    int pulses, changes;
    bit saw_run;

    vecs[0] = '{32'd10, 32'd9, 1'b0};
    vecs[1] = '{32'd10, 32'd10, 1'b1};
    vecs[2] = '{32'd0, 32'd0, 1'b1};
    vecs[3] = '{32'd0, 32'd1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[6] = '{32'd10, 32'h8000_000A, 1'b0};
    vecs[7] = '{32'd5, 32'd5, 1'b1};

    cif.count = 32'd0;
    cif.cnt_max = 32'd100;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_state", cif.state, M_IDLE);
    chk("rst_en", cif.cnt_en, 0);
    chk("rst_clr", cif.cnt_clr, 0);
    chk("rst_wrap", cif.wrap, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", cif.state, M_IDLE);

    // run press latency: change on the 7th posedge
    btn_run = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) chk("lat_before_state", cif.state, M_IDLE);
      if (i == 7) begin
        chk("lat_run_state", cif.state, M_RUN);
        chk("lat_run_en", cif.cnt_en, 1);
      end
    end
    btn_run = 1'b0;
    repeat (DB + 3) tick();
    press(1, 0);
    chk("second_press_state", cif.state, M_PAUSE);
    chk("second_press_en", cif.cnt_en, 0);
    press(1, 0);
    chk("resume_state", cif.state, M_RUN);

    // terminal-count vector table
    foreach (vecs[v]) begin
      press(0, 1);
      cif.cnt_max = vecs[v].max;
      cif.count = ~vecs[v].max;
      press(1, 0);
      chk($sformatf("vec%0d_run", v), cif.state, M_RUN);
      cif.count = vecs[v].cnt;
      tick();
      chk($sformatf("vec%0d_wrap", v), cif.wrap, vecs[v].exp_wrap);
      chk($sformatf("vec%0d_clr", v), cif.cnt_clr, vecs[v].exp_wrap);
      chk($sformatf("vec%0d_state", v), cif.state,
          (vecs[v].exp_wrap && ONESHOT) ? M_IDLE : M_RUN);
      cif.count = ~vecs[v].max;
      tick();
      chk($sformatf("vec%0d_wrap_once", v), cif.wrap, 0);
      chk($sformatf("vec%0d_clr_once", v), cif.cnt_clr, 0);
    end

    // cnt_max = 0 held in RUN: wrap every cycle while still running
    press(0, 1);
    cif.cnt_max = 32'd0;
    cif.count = 32'd5;
    press(1, 0);
    cif.count = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("max0_wrap%0d", i), cif.wrap, (i == 0 || !ONESHOT) ? 1 : 0);
    end
    cif.count = 32'd5;
    cif.cnt_max = 32'd100;

    // simultaneous run+clr from PAUSE
    press(0, 1);
    press(1, 0);
    press(1, 0);
    chk("prio_pause", cif.state, M_PAUSE);
    pulses = 0;
    saw_run = 0;
    btn_run = 1'b1;
    btn_clr = 1'b1;
    for (int i = 0; i < 2 * (DB + 3); i++) begin
      tick();
      if (i == DB + 2) begin btn_run = 1'b0; btn_clr = 1'b0; end
      pulses += int'(cif.cnt_clr);
      if (cif.state == M_RUN) saw_run = 1;
    end
    chk("prio_state", cif.state, M_IDLE);
    chk("prio_clr_pulses", pulses, 1);
    chk("prio_no_run", saw_run, 0);

    // bounce: 2 high / 2 low x5, then stable high
    s0 = cif.state;
    changes = 0;
    for (int b = 0; b < 5; b++) begin
      btn_run = 1'b1; tick(); tick();
      btn_run = 1'b0; tick(); tick();
      if (cif.state != s0) changes++;
    end
    repeat (DB + 3) begin tick(); if (cif.state != s0) changes++; end
    chk("bounce_no_change", changes, 0);
    btn_run = 1'b1;
    changes = 0;
    for (int i = 0; i < 15; i++) begin
      logic [1:0] prev;
      prev = cif.state;
      tick();
      if (cif.state != prev) changes++;
    end
    chk("bounce_one_toggle", changes, 1);
    chk("bounce_state", cif.state, M_RUN);
    btn_run = 1'b0;
    repeat (DB + 3) tick();

    // off-grid asynchronous reset while running
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_en", cif.cnt_en, 0);
    chk("async_rst_state", cif.state, M_IDLE);
    chk("async_rst_clr", cif.cnt_clr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_en", cif.cnt_en, 0);
    chk("rel_clr", cif.cnt_clr, 0);
    chk("rel_wrap", cif.wrap, 0);
    chk("rel_state", cif.state, M_IDLE);

    // clr held through reset: one pulse, 7 posedges after release
    btn_clr = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("held_clr_e%0d", i), cif.cnt_clr, (i == DB + 3) ? 1 : 0);
    end
    btn_clr = 1'b0;
    repeat (DB + 3) tick();

    // randomized run against the reference model
    rst_n = 1'b0;
    cif.cnt_max = 32'd3;
    cif.count = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 9) == 0) btn_clr = ~btn_clr;
      if (m_state == M_IDLE && $urandom_range(0, 15) == 0) cif.cnt_max = $urandom_range(0, 6);
      cif.count = $urandom_range(0, 7);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_state", cif.state, m_state);
      chk("rnd_en", cif.cnt_en, m_en);
      chk("rnd_clr", cif.cnt_clr, m_clr);
      chk("rnd_wrap", cif.wrap, m_wrap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
